// File: rtl/frame_scan_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_scan_reader_pkg
//  Description : Shared definitions for the frame scan reader.
//                - FSM state encoding (IDLE, PRIME, STREAM, DRAIN, GAP; 3 bits)
//                - Helper for the RAM address width, $clog2(DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_scan_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_GAP    = 3'd4
    } state_t;

    localparam int DEFAULT_DEPTH  = 256;
    localparam int DEFAULT_ADDR_W = $clog2(DEFAULT_DEPTH);

    // Address width for a RAM of the given depth (never narrower than 1 bit).
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : frame_scan_reader
//  Description : Streams one full frame of pixels out of the framebuffer RAM
//                read port onto a valid/ready pixel stream with frame markers.
//                Absorbs the one-cycle RAM read latency by driving the read
//                address with the next value of the read pointer.
//  Ports       : clk        - system clock (RAM read clock is the same clock)
//                rst        - asynchronous, active-high reset
//                run        - level; frames stream back to back while high
//                raddr      - RAM read address
//                rdata      - RAM read data (mem[raddr] of previous cycle)
//                pix_data   - pixel word
//                pix_valid  - pix_data is valid
//                pix_ready  - serializer accepts the pixel
//                pix_last   - marks pixel DEPTH-1 of the frame
//                frame_done - one-cycle pulse after the last-pixel handshake
//                busy       - high in every state except IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_scan_reader
    import frame_scan_reader_pkg::*;
#(
    parameter int SIZE      = 8,
    parameter int DEPTH     = 256,
    parameter int FRAME_GAP = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    output logic [addr_bits(DEPTH)-1:0] raddr,
    input  logic [SIZE-1:0]             rdata,
    output logic [SIZE-1:0]             pix_data,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic                        pix_last,
    output logic                        frame_done,
    output logic                        busy
);

    localparam int AW = addr_bits(DEPTH);
    // A zero gap still gets a 1-bit counter so the port/vector widths stay legal.
    localparam int GW = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [GW-1:0] GAP_TC    = GW'((FRAME_GAP > 0) ? (FRAME_GAP - 1) : 0);

    state_t          state;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_ptr_next;
    logic [GW-1:0]   gap_cnt;
    logic            load;
    logic            handshake;

    // The output register is refilled whenever it is empty or being drained.
    assign load      = (state == ST_STREAM) && (!pix_valid || pix_ready);
    assign handshake = pix_valid && pix_ready;

    // raddr carries rd_ptr's next value so that rdata lines up with rd_ptr
    // one cycle later, hiding the RAM read latency. DEPTH is a power of two,
    // so the natural binary wrap of the increment is the modulo-DEPTH wrap.
    always_comb begin
        rd_ptr_next = rd_ptr;
        if (state == ST_IDLE) begin
            rd_ptr_next = '0;
        end else if (load) begin
            rd_ptr_next = rd_ptr + AW'(1);
        end
    end

    assign raddr = rd_ptr_next;
    assign busy  = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            rd_ptr     <= '0;
            gap_cnt    <= '0;
            pix_data   <= '0;
            pix_valid  <= 1'b0;
            pix_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            rd_ptr     <= rd_ptr_next;

            // Output register: a load always wins over a plain handshake,
            // which keeps one pixel per clock under continuous ready.
            if (load) begin
                pix_data  <= rdata;
                pix_valid <= 1'b1;
                pix_last  <= (rd_ptr == LAST_ADDR);
            end else if (handshake) begin
                pix_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state <= ST_PRIME;
                    end
                end

                ST_PRIME: begin
                    state <= ST_STREAM;
                end

                ST_STREAM: begin
                    if (load && (rd_ptr == LAST_ADDR)) begin
                        state <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (handshake && pix_last) begin
                        frame_done <= 1'b1;
                        if (FRAME_GAP == 0) begin
                            state <= run ? ST_PRIME : ST_IDLE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end
                    end
                end

                ST_GAP: begin
                    // Counter stops at its terminal count; run is sampled only here.
                    if (gap_cnt == GAP_TC) begin
                        gap_cnt <= '0;
                        state   <= run ? ST_PRIME : ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_scan_reader
//  Description : Directed self-checking bench for frame_scan_reader with
//                DEPTH=8, FRAME_GAP=4 and a behavioural simple dual-port RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_scan_reader;

    localparam int SIZE      = 8;
    localparam int DEPTH     = 8;
    localparam int FRAME_GAP = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            run;
    logic [2:0]      raddr;
    logic [7:0]      rdata;
    logic [7:0]      pix_data;
    logic            pix_valid;
    logic            pix_ready;
    logic            pix_last;
    logic            frame_done;
    logic            busy;

    // RAM write port (CPU side)
    logic            we;
    logic [2:0]      waddr;
    logic [7:0]      wdata;
    logic [7:0]      mem [DEPTH];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int fd_cnt = 0;
    logic [7:0] exp_pix [DEPTH];

    always #5 clk = ~clk;

    // Synchronous-read RAM, read-before-write on a same-address collision.
    always @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

    frame_scan_reader #(
        .SIZE      (SIZE),
        .DEPTH     (DEPTH),
        .FRAME_GAP (FRAME_GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .raddr      (raddr),
        .rdata      (rdata),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_last   (pix_last),
        .frame_done (frame_done),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock; everything is sampled/driven 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic ram_write(input logic [2:0] a, input logic [7:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    // Accept n_pix pixels, checking order/content, pix_last and stall stability.
    task automatic collect(input int n_pix, input bit rnd, input int drop_run_at,
                           input int wr_at, output int first_c, output int last_c);
        int idx = 0;
        int budget = 300;
        bit stalled = 0;
        logic [7:0] held_d = '0;
        logic held_l = 1'b0;
        first_c = -1;
        last_c  = -1;
        while (idx < n_pix && budget > 0) begin
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                check("stall_valid", pix_valid, 1);
                check("stall_data", pix_data, held_d);
                check("stall_last", pix_last, held_l);
            end
            we = 1'b0;
            if (pix_valid && pix_ready) begin
                if (idx == wr_at) begin
                    we = 1'b1; waddr = 3'd5; wdata = 8'hAA;
                end
                check($sformatf("pix%0d_data", idx), pix_data, exp_pix[idx]);
                check($sformatf("pix%0d_last", idx), pix_last, (idx == DEPTH - 1));
                if (idx == 0) first_c = cyc;
                if (idx == drop_run_at) run = 1'b0;
                last_c = cyc;
                idx++;
                stalled = 0;
            end else if (pix_valid) begin
                stalled = 1;
                held_d  = pix_data;
                held_l  = pix_last;
            end else begin
                stalled = 0;
            end
            tick();
            budget--;
        end
        we = 1'b0;
        if (idx < n_pix) check("collect_timeout", idx, n_pix);
    endtask

    task automatic wait_idle();
        int budget = 40;
        while (busy && budget > 0) begin
            tick();
            budget--;
        end
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int c, f1, l1, f2, l2, f3, l3, fd0, vcount;

        rst = 1'b1; run = 1'b0; pix_ready = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0;
        tick(); tick();

        // ---------------- reset state ----------------
        check("rst_valid", pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_raddr", raddr, 0);
        check("rst_data", pix_data, 0);
        check("rst_last", pix_last, 0);
        check("rst_fdone", frame_done, 0);

        for (int i = 0; i < DEPTH; i++) begin
            ram_write(3'(i), 8'(10 + i));
            exp_pix[i] = 8'(10 + i);
        end
        rst = 1'b0;
        tick(); tick();
        check("idle_no_run_busy", busy, 0);

        // ---------------- basic frame ----------------
        run = 1'b1;
        c = cyc;
        tick();                               // edge k: PRIME
        check("a_prime_busy", busy, 1);
        check("a_prime_valid", pix_valid, 0);
        run = 1'b0;                           // not sampled again until end of GAP
        tick();                               // edge k+1: STREAM
        check("a_stream_valid", pix_valid, 0);
        fd0 = fd_cnt;
        collect(8, 1'b0, -1, -1, f1, l1);
        check("a_first_lat", f1 - c, 3);
        check("a_span", l1 - f1, 7);
        check("a_fdone", frame_done, 1);
        check("a_valid_after", pix_valid, 0);
        tick();
        check("a_fdone_pulse", frame_done, 0);
        tick(); tick();
        check("a_gap_busy", busy, 1);
        tick();
        check("a_idle_busy", busy, 0);
        check("a_fd_count", fd_cnt - fd0, 1);

        // ---------------- random backpressure ----------------
        run = 1'b1;
        tick();
        run = 1'b0;
        fd0 = fd_cnt;
        collect(8, 1'b1, -1, -1, f1, l1);
        check("b_fdone", frame_done, 1);
        wait_idle();
        check("b_fd_count", fd_cnt - fd0, 1);

        // ---------------- continuous frames ----------------
        run = 1'b1;
        fd0 = fd_cnt;
        collect(8, 1'b0, -1, -1, f1, l1);
        check("c_fdone1", frame_done, 1);
        check("c_raddr_wrap", raddr, 0);
        collect(8, 1'b0, -1, -1, f2, l2);
        check("c_gap12", f2 - l1, FRAME_GAP + 3);
        collect(8, 1'b0, 0, -1, f3, l3);
        check("c_gap23", f3 - l2, FRAME_GAP + 3);
        wait_idle();
        check("c_fd_count", fd_cnt - fd0, 3);

        // ---------------- run drop mid-frame ----------------
        run = 1'b1;
        fd0 = fd_cnt;
        collect(8, 1'b0, 3, -1, f1, l1);
        check("d_fdone", frame_done, 1);
        tick(); tick(); tick();
        check("d_gap_busy", busy, 1);
        tick();
        check("d_idle_busy", busy, 0);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (pix_valid) vcount++;
            tick();
        end
        check("d_no_more_valid", vcount, 0);
        check("d_fd_count", fd_cnt - fd0, 1);

        // ---------------- concurrent write ----------------
        exp_pix[5] = 8'hAA;
        run = 1'b1;
        tick();
        run = 1'b0;
        collect(8, 1'b0, -1, 1, f1, l1);
        wait_idle();
        ram_write(3'd5, 8'd15);
        exp_pix[5] = 8'd15;

        // ---------------- reset mid-frame ----------------
        run = 1'b1;
        fd0 = fd_cnt;
        collect(4, 1'b0, -1, -1, f1, l1);
        pix_ready = 1'b0;
        tick();
        check("f_stall_data", pix_data, 14);
        check("f_stall_valid", pix_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("f_rst_valid", pix_valid, 0);
        check("f_rst_busy", busy, 0);
        check("f_rst_raddr", raddr, 0);
        check("f_rst_fdone", frame_done, 0);
        tick();
        check("f_rst_hold_valid", pix_valid, 0);
        rst = 1'b0;
        pix_ready = 1'b1;
        c = cyc;
        collect(8, 1'b0, 0, -1, f1, l1);
        check("f_restart_lat", f1 - c, 3);
        check("f_fdone", frame_done, 1);
        wait_idle();
        check("f_fd_count", fd_cnt - fd0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
